seg7_rx_decoder: RTL and testbench



---
 rtl/seg7_rx_if.sv | 40 ++++
 rtl/seg7_rx_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_seg7_rx_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg7_rx_if.sv
// Bus between a multiplexed active-low 7-segment display path and its decoder.
// SEG7RX_DP_EN adds the decimal-point input and the per-digit dp_out status.
interface seg7_rx_if #(
    parameter int NDIG = 4,
    parameter int ERRW = 8
);
    logic [6:0]        seg_in;
    logic [NDIG-1:0]   dig_sel;
`ifdef SEG7RX_DP_EN
    logic              seg_dp;
    logic [NDIG-1:0]   dp_out;
`endif
    logic [4*NDIG-1:0] dato;
    logic [NDIG-1:0]   blank;
    logic              digit_valid;
    logic [2:0]        digit_idx;
    logic              err;
    logic [ERRW-1:0]   err_cnt;
    logic [1:0]        state_dbg;

    // No valid/ready here: the display bus is free-running, and the status
    // outputs are single-cycle pulses that the consumer must sample every cycle.
    modport master (
`ifdef SEG7RX_DP_EN
        output seg_dp,
        input  dp_out,
`endif
        output seg_in, dig_sel,
        input  dato, blank, digit_valid, digit_idx, err, err_cnt, state_dbg
    );

    modport slave (
`ifdef SEG7RX_DP_EN
        input  seg_dp,
        output dp_out,
`endif
        input  seg_in, dig_sel,
        output dato, blank, digit_valid, digit_idx, err, err_cnt, state_dbg
    );
endinterface

// File: rtl/seg7_rx_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus.
// Optional decimal-point capture is enabled by defining SEG7RX_DP_EN.
module seg7_rx_decoder #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int ERRW          = 8
) (
    input logic       clk,
    input logic       rst,
    seg7_rx_if.slave  bus
);
    localparam int SW = NDIG + 8;
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [6:0]        seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [NDIG-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic [SW-1:0]     prev_q, prev_d, cap_q, cap_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*NDIG-1:0] dato_q, dato_d;
    logic [NDIG-1:0]   blank_q, blank_d;
    logic              dv_q, dv_d, err_q, err_d;
    logic [2:0]        idx_q, idx_d;
    logic [ERRW-1:0]   err_cnt_q, err_cnt_d;
`ifdef SEG7RX_DP_EN
    logic              dp_s1_q, dp_s1_d, dp_s2_q, dp_s2_d;
    logic [NDIG-1:0]   dp_out_q, dp_out_d;
`endif

    logic [SW-1:0]     sample;
    logic              dp_s, changed, any_low;
    logic [3:0]        n_low;
    logic [2:0]        low_idx;
    logic [4:0]        dec;

    // Returns {legal, nibble}; the all-off pattern is handled by the caller.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1000000: decode_seg = {1'b1, 4'h0};
            7'b1111001: decode_seg = {1'b1, 4'h1};
            7'b0100100: decode_seg = {1'b1, 4'h2};
            7'b0110000: decode_seg = {1'b1, 4'h3};
            7'b0011001: decode_seg = {1'b1, 4'h4};
            7'b0010010: decode_seg = {1'b1, 4'h5};
            7'b0000010: decode_seg = {1'b1, 4'h6};
            7'b1111000: decode_seg = {1'b1, 4'h7};
            7'b0000000: decode_seg = {1'b1, 4'h8};
            7'b0011000: decode_seg = {1'b1, 4'h9};
            7'b0001000: decode_seg = {1'b1, 4'hA};
            7'b0000011: decode_seg = {1'b1, 4'hB};
            7'b0100111: decode_seg = {1'b1, 4'hC};
            7'b0100001: decode_seg = {1'b1, 4'hD};
            7'b0000110: decode_seg = {1'b1, 4'hE};
            7'b0001110: decode_seg = {1'b1, 4'hF};
            default:    decode_seg = 5'b0_0000;
        endcase
    endfunction

    always_comb begin
        seg_s1_d  = bus.seg_in;
        seg_s2_d  = seg_s1_q;
        sel_s1_d  = bus.dig_sel;
        sel_s2_d  = sel_s1_q;
        state_d   = state_q;
        cap_d     = cap_q;
        dato_d    = dato_q;
        blank_d   = blank_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;
        idx_d     = 3'd0;
        err_cnt_d = err_cnt_q;
        dec       = 5'b0;
        n_low     = 4'd0;
        low_idx   = 3'd0;
`ifdef SEG7RX_DP_EN
        dp_s1_d   = bus.seg_dp;
        dp_s2_d   = dp_s1_q;
        dp_out_d  = dp_out_q;
        dp_s      = dp_s2_q;
`else
        dp_s      = 1'b1;
`endif
        sample  = {dp_s, sel_s2_q, seg_s2_q};
        changed = (sample != prev_q);
        prev_d  = sample;
        any_low = ~&sel_s2_q;
        for (int i = 0; i < NDIG; i++) begin
            if (!sel_s2_q[i]) begin
                n_low   = n_low + 4'd1;
                low_idx = 3'(i);
            end
        end
        cnt_d = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));

        case (state_q)
            S_IDLE: begin
                // All-ones never matches a real digit, so the next one is always captured.
                cap_d = '1;
                if (any_low) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (!any_low) begin
                    state_d = S_IDLE;
                end else if (!changed && cnt_d == CNT_MAX) begin
                    // A glitch that settles back to the last captured sample is not news.
                    if (sample == cap_q) begin
                        state_d = S_HOLD;
                    end else begin
                        // Outputs are registered here so they appear during CAPTURE.
                        state_d = S_CAPTURE;
                        cap_d   = sample;
                        if (n_low == 4'd1) begin
                            dv_d  = 1'b1;
                            idx_d = low_idx;
                            dec   = decode_seg(seg_s2_q);
                            for (int i = 0; i < NDIG; i++) begin
                                if (3'(i) == low_idx) begin
`ifdef SEG7RX_DP_EN
                                    dp_out_d[i] = ~dp_s2_q;
`endif
                                    if (seg_s2_q == 7'h7f) begin
                                        blank_d[i] = 1'b1;
                                    end else if (dec[4]) begin
                                        dato_d[4*i +: 4] = dec[3:0];
                                        blank_d[i]       = 1'b0;
                                    end
                                end
                            end
                            if (seg_s2_q != 7'h7f && !dec[4]) err_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_CAPTURE: state_d = S_HOLD;
            S_HOLD: begin
                if (sample != cap_q) state_d = any_low ? S_SETTLE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (err_d && err_cnt_q != {ERRW{1'b1}}) err_cnt_d = err_cnt_q + ERRW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q  <= '1;
            seg_s2_q  <= '1;
            sel_s1_q  <= '1;
            sel_s2_q  <= '1;
            prev_q    <= '1;
            cap_q     <= '1;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            dato_q    <= '0;
            blank_q   <= '1;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= 3'd0;
            err_cnt_q <= '0;
`ifdef SEG7RX_DP_EN
            dp_s1_q   <= 1'b1;
            dp_s2_q   <= 1'b1;
            dp_out_q  <= '0;
`endif
        end else begin
            seg_s1_q  <= seg_s1_d;
            seg_s2_q  <= seg_s2_d;
            sel_s1_q  <= sel_s1_d;
            sel_s2_q  <= sel_s2_d;
            prev_q    <= prev_d;
            cap_q     <= cap_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            dato_q    <= dato_d;
            blank_q   <= blank_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
`ifdef SEG7RX_DP_EN
            dp_s1_q   <= dp_s1_d;
            dp_s2_q   <= dp_s2_d;
            dp_out_q  <= dp_out_d;
`endif
        end
    end

    assign bus.dato        = dato_q;
    assign bus.blank       = blank_q;
    assign bus.digit_valid = dv_q;
    assign bus.digit_idx   = idx_q;
    assign bus.err         = err_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.state_dbg   = state_q;
`ifdef SEG7RX_DP_EN
    assign bus.dp_out      = dp_out_q;
`endif
endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Directed bench for seg7_rx_decoder: latency, scan, glitch, illegal patterns,
// error saturation, multi-anode, idle and mid-settle reset.
module tb_seg7_rx_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad = 0;
    int   dv_n = 0;
    int   err_n = 0;
    logic [2:0] last_idx = 3'd0;

    seg7_rx_if #(.NDIG(4), .ERRW(8)) bus ();

    seg7_rx_decoder #(.NDIG(4), .STABLE_CYCLES(4), .ERRW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse tally taken on the active edge, before the registers update.
    always @(posedge clk) begin
        if (bus.digit_valid) begin
            dv_n++;
            last_idx = bus.digit_idx;
        end
        if (bus.err) err_n++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_bus(input logic [3:0] sel, input logic [6:0] seg);
        bus.dig_sel = sel;
        bus.seg_in  = seg;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int lat, dv0, err0;
    logic seen_dv;

    initial begin
        bus.dig_sel = 4'b1111;
        bus.seg_in  = 7'h7f;
`ifdef SEG7RX_DP_EN
        bus.seg_dp  = 1'b1;
`endif
        cycles(3);
        check("rst_dato", 32'(bus.dato), 32'h0);
        check("rst_blank", 32'(bus.blank), 32'hf);
        check("rst_dv", 32'(bus.digit_valid), 32'h0);
        check("rst_idx", 32'(bus.digit_idx), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_errcnt", 32'(bus.err_cnt), 32'h0);
        check("rst_state", 32'(bus.state_dbg), 32'h0);
        rst = 1'b0;
        cycles(3);

        // First capture and its latency
        dv0 = dv_n;
        set_bus(4'b1110, 7'b0110000);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.digit_valid && lat == 0) begin
                lat = c;
                check("t1_idx", 32'(bus.digit_idx), 32'h0);
                check("t1_dato0", 32'(bus.dato[3:0]), 32'h3);
                check("t1_blank0", 32'(bus.blank[0]), 32'h0);
            end
        end
        check("t1_latency", 32'(lat), 32'd6);
        check("t1_pulses", 32'(dv_n - dv0), 32'd1);

        // Scan four digits
        dv0 = dv_n;
        set_bus(4'b1110, 7'b0010010); cycles(16);
        set_bus(4'b1101, 7'b0001000); cycles(16);
        set_bus(4'b1011, 7'b0000011); cycles(16);
        set_bus(4'b0111, 7'b1111111); cycles(16);
        check("scan_dato", 32'(bus.dato), 32'h0BA5);
        check("scan_blank", 32'(bus.blank), 32'b1000);
        check("scan_pulses", 32'(dv_n - dv0), 32'd4);
        check("scan_last_idx", 32'(last_idx), 32'd3);

        // Short glitch on a steady digit
        set_bus(4'b1101, 7'b1111001); cycles(16);
        dv0 = dv_n;
        set_bus(4'b1101, 7'b0000000); cycles(2);
        set_bus(4'b1101, 7'b1111001); cycles(16);
        check("glitch_pulses", 32'(dv_n - dv0), 32'd0);
        check("glitch_dato1", 32'(bus.dato[7:4]), 32'h1);
        check("glitch_dato", 32'(bus.dato), 32'h0B15);

        // One illegal pattern
        dv0 = dv_n;
        err0 = err_n;
        set_bus(4'b1011, 7'b1010101);
        seen_dv = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.err && !seen_dv) begin
                seen_dv = 1'b1;
                check("ill_dv_with_err", 32'(bus.digit_valid), 32'h1);
                check("ill_idx", 32'(bus.digit_idx), 32'h2);
            end
        end
        check("ill_seen", 32'(seen_dv), 32'h1);
        check("ill_errcnt", 32'(bus.err_cnt), 32'd1);
        check("ill_err_pulses", 32'(err_n - err0), 32'd1);
        check("ill_dv_pulses", 32'(dv_n - dv0), 32'd1);
        check("ill_dato2", 32'(bus.dato[11:8]), 32'hB);
        check("ill_blank", 32'(bus.blank), 32'b1000);

        // Saturation of the error counter
        err0 = err_n;
        for (int k = 0; k < 300; k++) begin
            set_bus(4'b1011, (k % 2 == 0) ? 7'b1010100 : 7'b1010101);
            cycles(8);
            if (k == 200) check("sat_mid", 32'(bus.err_cnt), 32'd202);
        end
        check("sat_errcnt", 32'(bus.err_cnt), 32'd255);
        check("sat_err_pulses", 32'(err_n - err0), 32'd300);
        check("sat_dato", 32'(bus.dato), 32'h0B15);

        // Two anodes low
        dv0 = dv_n;
        err0 = err_n;
        set_bus(4'b1100, 7'b1000000); cycles(12);
        check("multi_err_pulses", 32'(err_n - err0), 32'd1);
        check("multi_dv_pulses", 32'(dv_n - dv0), 32'd0);
        check("multi_dato", 32'(bus.dato), 32'h0B15);
        check("multi_errcnt", 32'(bus.err_cnt), 32'd255);

        // No anode low
        dv0 = dv_n;
        err0 = err_n;
        set_bus(4'b1111, 7'b1000000); cycles(10);
        check("idle_state", 32'(bus.state_dbg), 32'h0);
        check("idle_pulses", 32'(dv_n - dv0 + err_n - err0), 32'd0);

        // Reset in the middle of settling
        dv0 = dv_n;
        set_bus(4'b1110, 7'b1111000);
        cycles(3);
        check("pre_rst_state", 32'(bus.state_dbg), 32'h1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("mrst_dato", 32'(bus.dato), 32'h0);
        check("mrst_blank", 32'(bus.blank), 32'hf);
        check("mrst_errcnt", 32'(bus.err_cnt), 32'h0);
        check("mrst_state", 32'(bus.state_dbg), 32'h0);
        check("mrst_pulses", 32'(dv_n - dv0), 32'd0);
        cycles(14);
        check("resume_pulses", 32'(dv_n - dv0), 32'd1);
        check("resume_dato", 32'(bus.dato), 32'h0007);
        check("resume_blank", 32'(bus.blank), 32'b1110);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
